// File: rtl/fir_tap_line.sv
// ---------------------------------------------------------------------------
// fir_tap_line
//
// Delay line feeding the in[] array of a direct-form FIR. Samples shift in
// at taps[0]; taps[ORDER] holds the oldest. A valid/ready pair upstream and
// downstream keeps the tap vector stable until the FIR result for it has
// been consumed.
//
// Optional feature macro: FIR_TAP_WARMUP_EN
//   defined   : taps_valid is withheld until ORDER+1 samples are loaded
//   undefined : taps_valid follows every accepted sample, including warm-up
//               (unloaded taps read 0)
//
// Parameters
//   DATA_W  sample width, unsigned
//   ORDER   filter order; ORDER+1 taps are exposed
//
// Ports
//   clock       in   rising-edge clock for all state
//   reset       in   synchronous, active-high reset
//   in_valid    in   upstream sample present
//   in_data     in   upstream sample
//   in_ready    out  a sample can be accepted this cycle (combinational)
//   flush       in   clear delay line and warm-up state, drops in_data
//   taps        out  delay-line contents, taps[0] newest
//   taps_valid  out  taps hold a new, consumable vector
//   taps_ready  in   downstream has consumed the result for this vector
//   fill_count  out  samples loaded, saturating at ORDER+1
//
// States
//   state | meaning
//   FILL  | fewer than ORDER+1 samples loaded since reset/flush
//   RUN   | delay line fully loaded; fill_count pinned at ORDER+1
// ---------------------------------------------------------------------------
module fir_tap_line #(
    parameter int DATA_W = 13,
    parameter int ORDER  = 18
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [DATA_W-1:0]             taps [0:ORDER],
    output logic                          taps_valid,
    input  logic                          taps_ready,
    output logic [$clog2(ORDER+2)-1:0]    fill_count
);

    localparam int CNT_W = $clog2(ORDER + 2);
    localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(ORDER);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  fill_nxt;
    logic              valid_nxt;
    logic              accept;

    // A pending, unconsumed vector blocks new samples; consuming it frees
    // the slot in the same cycle so the line can stream at full rate.
    assign in_ready = !flush && !(taps_valid && !taps_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FILL;
            fill_count <= '0;
            taps_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill_count <= fill_nxt;
            taps_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_count;
        valid_nxt = taps_valid;

        if (flush) begin
            state_nxt = FILL;
            fill_nxt  = '0;
            valid_nxt = 1'b0;
        end else begin
            if (accept && (state == FILL)) begin
                fill_nxt = fill_count + CNT_W'(1);
                if (fill_count == LAST_FILL) begin
                    state_nxt = RUN;
                end
            end

            if (accept) begin
`ifdef FIR_TAP_WARMUP_EN
                valid_nxt = (state_nxt == RUN);
`else
                valid_nxt = 1'b1;
`endif
            end else if (taps_ready) begin
                valid_nxt = 1'b0;
            end
        end
    end

    // Taps are stored as-is; any widening belongs to the FIR datapath.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i <= ORDER; i++) begin
                taps[i] <= '0;
            end
        end else if (accept) begin
            taps[0] <= in_data;
            for (int i = 1; i <= ORDER; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_line.sv
module tb_fir_tap_line;

    localparam int DW  = 13;
    localparam int ORD = 18;
    localparam int CW  = $clog2(ORD + 2);
`ifdef FIR_TAP_WARMUP_EN
    localparam bit WARM = 1'b1;
`else
    localparam bit WARM = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic           flush = 1'b0;
    logic [DW-1:0]  taps [0:ORD];
    logic           taps_valid;
    logic           taps_ready = 1'b1;
    logic [CW-1:0]  fill_count;

    fir_tap_line #(.DATA_W(DW), .ORDER(ORD)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .taps       (taps),
        .taps_valid (taps_valid),
        .taps_ready (taps_ready),
        .fill_count (fill_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic                 v;
        logic [ORD:0][DW-1:0] t;
        logic [CW-1:0]        f;
    } exp_t;

    exp_t                 sb [$];
    logic [ORD:0][DW-1:0] m_taps;
    int                   m_fill;
    int                   checks = 0;
    int                   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int nz_count();
        int n = 0;
        for (int i = 0; i <= ORD; i++) if (taps[i] != '0) n++;
        return n;
    endfunction

    task automatic model_clear();
        m_taps = '0;
        m_fill = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        m_taps = {m_taps[ORD-1:0], d};
        if (m_fill < ORD + 1) m_fill++;
        e.v = WARM ? (m_fill == ORD + 1) : 1'b1;
        e.t = m_taps;
        e.f = CW'(m_fill);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a sample and wait (bounded) for it to be accepted; returns 1
    // time unit after the accepting edge.
    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            n++;
            @(posedge clock);
            #2;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        tick();
        model_accept(d);
    endtask

    // Monitor: one vector is presented per accepted sample; compare it
    // against the oldest queued expectation.
    logic acc_prev = 1'b0;
    exp_t mon_e;
    int   bad;
    always @(negedge clock) begin
        if (acc_prev) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("vec_valid", int'(taps_valid), int'(mon_e.v));
                bad = -1;
                for (int i = ORD; i >= 0; i--) if (taps[i] != mon_e.t[i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL vec_taps idx=%0d actual=%0d required=%0d",
                             bad, taps[bad], mon_e.t[bad]);
                end
                chk("vec_fill", int'(fill_count), int'(mon_e.f));
            end
        end
        acc_prev = in_valid && in_ready && !reset;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_valid", int'(taps_valid), 0);
        chk("rst_fill", int'(fill_count), 0);
        chk("rst_taps_zero", nz_count(), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // single sample
        send(13'd5);
        in_valid = 1'b0;
        chk("one_valid", int'(taps_valid), WARM ? 0 : 1);
        chk("one_tap0", int'(taps[0]), 5);
        chk("one_tap18", int'(taps[18]), 0);
        chk("one_fill", int'(fill_count), 1);
        tick();
        chk("one_consumed_valid", int'(taps_valid), 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();

        // 1..19 back-to-back, then stall with sample 20 waiting
        for (int i = 1; i <= 19; i++) send(DW'(i));
        chk("seq19_valid", int'(taps_valid), 1);
        chk("seq19_tap0", int'(taps[0]), 19);
        chk("seq19_tap18", int'(taps[18]), 1);
        chk("seq19_fill", int'(fill_count), 19);
        taps_ready = 1'b0;
        in_data    = 13'd20;
        #1;
        chk("stall_in_ready", int'(in_ready), 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall_in_ready_hold", int'(in_ready), 0);
            chk("stall_valid_hold", int'(taps_valid), 1);
            chk("stall_tap0_frozen", int'(taps[0]), 19);
            chk("stall_tap18_frozen", int'(taps[18]), 1);
        end
        taps_ready = 1'b1;
        send(13'd20);
        in_valid = 1'b0;
        chk("resume_tap0", int'(taps[0]), 20);
        chk("resume_tap18", int'(taps[18]), 2);
        chk("resume_valid", int'(taps_valid), 1);
        chk("resume_fill_sat", int'(fill_count), 19);

        // impulse
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        send(13'd4095);
        for (int i = 0; i < 18; i++) send(13'd0);
        chk("imp_tap18", int'(taps[18]), 4095);
        chk("imp_tap17", int'(taps[17]), 0);
        send(13'd0);
        chk("imp_gone", nz_count(), 0);
        for (int i = 0; i < 4; i++) send(13'd0);
        in_valid = 1'b0;

        // flush in RUN drops the concurrent sample
        in_valid = 1'b1;
        in_data  = 13'd7;
        flush    = 1'b1;
        #1;
        chk("flush_in_ready", int'(in_ready), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk("flush_taps_zero", nz_count(), 0);
        chk("flush_fill", int'(fill_count), 0);
        chk("flush_valid", int'(taps_valid), 0);

        // reset mid-operation overrides a concurrent accept
        for (int i = 0; i < 10; i++) send(DW'(11 + i));
        reset    = 1'b1;
        in_data  = 13'd99;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_taps_zero", nz_count(), 0);
        chk("mid_rst_fill", int'(fill_count), 0);
        chk("mid_rst_valid", int'(taps_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        for (int i = 1; i <= 19; i++) send(DW'(100 + i));
        in_valid = 1'b0;
        chk("restart_valid", int'(taps_valid), 1);
        chk("restart_tap18", int'(taps[18]), 101);
        chk("restart_fill", int'(fill_count), 19);

        tick();
        tick();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
